// File: rtl/matrix_pkg.sv
// Shared types and helpers for the LED matrix row scanner.
package matrix_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ROW_W = 3;

    typedef logic [COLS-1:0] row_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Column drive value that leaves every LED dark.
    function automatic row_t col_off(input logic active_low);
        return active_low ? '1 : '0;
    endfunction

    // Map active-high pixel bits onto the column driver polarity.
    function automatic row_t col_drive(input row_t pix, input logic active_low);
        return active_low ? ~pix : pix;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Row-slot prescaler: counts 0..CLK_DIV-1 and flags the last blank cycle
// and the last cycle of the slot.
module scan_prescaler #(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic blank_end,
    output logic slot_end
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // With no blank period there is no blank_end cycle; index 0 is a dummy.
    localparam int BE = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    logic [PW-1:0] cnt;

    assign slot_end  = (cnt == PW'(CLK_DIV - 1));
    assign blank_end = (BLANK_CYCLES > 0) && (cnt == PW'(BE));

    // Free-running slot counter, wraps at the end of each slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (slot_end) cnt <= '0;
        else               cnt <= cnt + PW'(1);
    end

endmodule

// File: rtl/matrix_row_scanner.sv
// Row-scan driver for an 8x8 LED matrix with a double-buffered frame,
// per-slot blanking and frame-boundary buffer swap.
module matrix_row_scanner
    import matrix_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit COL_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    output logic             wr_ready,
    input  logic             frame_done,
    output logic             swap_pending,
    output logic [ROW_W-1:0] row_sel,
    output logic [COLS-1:0]  col_out,
    output logic             blank,
    output logic             frame_tick
);

    logic                       blank_end;
    logic                       slot_end;
    scan_state_e                state_q;
    scan_state_e                state_nxt;
    logic [ROW_W-1:0]           row_nxt;
    logic                       sel_q;
    logic                       sel_nxt;
    logic                       pending_nxt;
    logic                       wrap;
    logic                       swap_now;
    row_t [1:0][ROWS-1:0]       frame_q;
    logic                       blank_d;
    row_t                       col_d;
    logic                       tick_d;

    scan_prescaler #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_presc (
        .clk       (clk),
        .rst_n     (rst_n),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    // Frame boundary is the last cycle of row 7's slot.
    assign wrap     = slot_end && (row_sel == ROW_W'(ROWS - 1));
    assign swap_now = wrap && swap_pending;
    assign row_nxt  = slot_end ? row_sel + ROW_W'(1) : row_sel;
    assign sel_nxt  = swap_now ? ~sel_q : sel_q;

    // A request arriving while a swap is pending (or on the swap edge) is ignored.
    always_comb begin
        pending_nxt = swap_pending;
        if (swap_now)        pending_nxt = 1'b0;
        else if (frame_done) pending_nxt = 1'b1;
    end

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BLANK;
        else        state_q <= state_nxt;
    end

    // Next scan state: each slot opens blanked, then drives after the gap.
    always_comb begin
        state_nxt = state_q;
        if (BLANK_CYCLES == 0) state_nxt = DRIVE;
        else if (slot_end)     state_nxt = BLANK;
        else if (blank_end)    state_nxt = DRIVE;
    end

    // Output values for the next cycle, built from next-cycle row and front
    // select so row_sel, blank and col_out always move together.
    always_comb begin
        blank_d = (state_nxt == BLANK);
        col_d   = col_off(COL_ACTIVE_LOW);
        if (!blank_d) col_d = col_drive(frame_q[sel_nxt][row_nxt], COL_ACTIVE_LOW);
        tick_d  = wrap;
    end

    // Registered display outputs and row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sel    <= '0;
            blank      <= 1'b1;
            col_out    <= col_off(COL_ACTIVE_LOW);
            frame_tick <= 1'b0;
        end else begin
            row_sel    <= row_nxt;
            blank      <= blank_d;
            col_out    <= col_d;
            frame_tick <= tick_d;
        end
    end

    // Swap handshake: front select, pending flag and write-ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= 1'b0;
            swap_pending <= 1'b0;
            wr_ready     <= 1'b1;
        end else begin
            sel_q        <= sel_nxt;
            swap_pending <= pending_nxt;
            wr_ready     <= !pending_nxt;
        end
    end

    // Back-buffer writes; writes are blocked while a swap is pending, so the
    // swap edge never coincides with a write and the front is never touched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (wr_valid && wr_ready) begin
            frame_q[~sel_q][wr_row] <= wr_data;
        end
    end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Self-checking bench for matrix_row_scanner against a cycle-count based
// behavioural model of the display (CLK_DIV=8, BLANK_CYCLES=2, active-low).
module tb_matrix_row_scanner;

    localparam int CLK_DIV = 8;
    localparam int BLANK   = 2;
    localparam int FRAME   = 8 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic       frame_done = 1'b0;
    logic       wr_ready;
    logic       swap_pending;
    logic [2:0] row_sel;
    logic [7:0] col_out;
    logic       blank;
    logic       frame_tick;

    matrix_row_scanner #(
        .CLK_DIV        (CLK_DIV),
        .BLANK_CYCLES   (BLANK),
        .COL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .frame_done   (frame_done),
        .swap_pending (swap_pending),
        .row_sel      (row_sel),
        .col_out      (col_out),
        .blank        (blank),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    // Model: t = cycles since reset release; displayed/back frames as arrays.
    int         t;
    logic [7:0] mfront [8];
    logic [7:0] mback  [8];
    bit         mpend;
    int         checks = 0;
    int         passed = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        mpend = 0;
        for (int i = 0; i < 8; i++) begin
            mfront[i] = '0;
            mback[i]  = '0;
        end
    endtask

    task automatic check_outputs();
        int p, r;
        logic eb;
        p  = t % CLK_DIV;
        r  = (t / CLK_DIV) % 8;
        eb = (p < BLANK);
        chk("row_sel",      {5'd0, row_sel},      8'(r));
        chk("blank",        {7'd0, blank},        {7'd0, eb});
        chk("col_out",      col_out,              eb ? 8'hFF : ~mfront[r]);
        chk("frame_tick",   {7'd0, frame_tick},   {7'd0, (t % FRAME == 0) && (t > 0)});
        chk("swap_pending", {7'd0, swap_pending}, {7'd0, mpend});
        chk("wr_ready",     {7'd0, wr_ready},     {7'd0, !mpend});
    endtask

    // One clock: drive inputs, advance the model across the edge, check.
    task automatic step(input logic v, input logic [2:0] r, input logic [7:0] d, input logic fd);
        logic [7:0] tmp;
        wr_valid = v; wr_row = r; wr_data = d; frame_done = fd;
        @(posedge clk);
        if (v && !mpend) mback[r] = d;
        if ((t % FRAME == FRAME - 1) && mpend) begin
            for (int i = 0; i < 8; i++) begin
                tmp = mfront[i]; mfront[i] = mback[i]; mback[i] = tmp;
            end
            mpend = 0;
        end else if (fd) begin
            mpend = 1;
        end
        t++;
        #1;
        wr_valid = 0; frame_done = 0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    initial begin
        // 1. reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs();
        @(negedge clk) rst_n = 1'b1;
        #1 check_outputs();

        // 2/3. walking-one frame, frame_done with last write, dropped write
        for (int r = 0; r < 8; r++) step(1'b1, 3'(r), 8'(8'h01 << r), r == 7);
        step(1'b1, 3'd3, 8'hAA, 1'b0);
        chk("dropped_ready", {7'd0, wr_ready}, 8'h00);
        idle(2 * FRAME);

        // Randomized writes and swap requests
        for (int i = 0; i < 4 * FRAME; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 $urandom_range(0, 19) == 0);

        // 4. frame_done in the frame_tick cycle: swap one frame later
        for (int i = 0; i < 3 * FRAME && mpend; i++) idle(1);
        chk("wait_no_pending", {7'd0, mpend}, 8'h00);
        for (int r = 0; r < 8; r++) step(1'b1, 3'(r), 8'($urandom), 1'b0);
        for (int i = 0; i < FRAME && (t % FRAME != 0); i++) idle(1);
        chk("wait_tick_phase", {7'd0, frame_tick}, 8'h01);
        step(1'b0, 3'd0, 8'h00, 1'b1);
        idle(FRAME + 4);

        // 6. async reset in row 5 with a swap pending
        for (int r = 0; r < 8; r++) step(1'b1, 3'(r), 8'($urandom) | 8'h01, r == 7);
        for (int i = 0; i < FRAME && ((t / CLK_DIV) % 8 != 5); i++) idle(1);
        chk("wait_row5", {5'd0, row_sel}, 8'd5);
        chk("pending_row5", {7'd0, swap_pending}, 8'h01);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        @(posedge clk);
        #1 check_outputs();
        @(negedge clk) rst_n = 1'b1;
        idle(2 * FRAME);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
